// File: rtl/dmem_bus_bridge.sv
// rtl/dmem_bus_bridge.sv - MEM-stage request to registered Wishbone-classic master cycle bridge
// Holds one bus cycle per request, aborts silently on flush, forces completion on watchdog expiry.
module dmem_bus_bridge #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int DATA_WIDTH     = 16,
   parameter int ADDR_WIDTH     = 16
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    dmem_action_cyc,
   input  logic                    dmem_action_stb,
   input  logic                    dmem_write,
   input  logic [DATA_WIDTH/8-1:0] dmem_byte_enable,
   input  logic [ADDR_WIDTH-1:0]   dmem_address,
   input  logic [DATA_WIDTH-1:0]   dmem_wdata,
   output logic                    dmem_resp,
   output logic [DATA_WIDTH-1:0]   dmem_rdata,
   output logic                    bus_timeout,
   output logic                    wb_cyc_o,
   output logic                    wb_stb_o,
   output logic                    wb_we_o,
   output logic [DATA_WIDTH/8-1:0] wb_sel_o,
   output logic [ADDR_WIDTH-1:0]   wb_adr_o,
   output logic [DATA_WIDTH-1:0]   wb_dat_o,
   input  logic [DATA_WIDTH-1:0]   wb_dat_i,
   input  logic                    wb_ack_i
);
   localparam int SEL_W = DATA_WIDTH / 8;
   localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);
   localparam logic [WD_W-1:0] WD_SAT  = WD_W'(TIMEOUT_CYCLES);

   typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;

   state_t                state_q, state_d;
   logic                  cyc_q, cyc_d;
   logic                  we_q, we_d;
   logic [SEL_W-1:0]      sel_q, sel_d;
   logic [ADDR_WIDTH-1:0] adr_q, adr_d;
   logic [DATA_WIDTH-1:0] dat_q, dat_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
   logic                  resp_q, resp_d;
   logic                  timeout_q, timeout_d;
   logic [WD_W-1:0]       wdog_q, wdog_d;
   logic                  abort_q, abort_d;

   logic request;
   logic kill;
   logic unused_addr_lsb;

   assign request         = dmem_action_cyc & dmem_action_stb;
   assign kill            = abort_q | ~request;
   assign unused_addr_lsb = dmem_address[0];

   always_comb begin
      state_d   = state_q;
      cyc_d     = cyc_q;
      we_d      = we_q;
      sel_d     = sel_q;
      adr_d     = adr_q;
      dat_d     = dat_q;
      rdata_d   = rdata_q;
      resp_d    = 1'b0;
      timeout_d = 1'b0;
      wdog_d    = wdog_q;
      abort_d   = abort_q;
      case (state_q)
         IDLE: begin
            if (request) begin
               we_d    = dmem_write;
               sel_d   = dmem_byte_enable;
               adr_d   = {dmem_address[ADDR_WIDTH-1:1], 1'b0};
               dat_d   = dmem_wdata;
               cyc_d   = 1'b1;
               wdog_d  = '0;
               abort_d = 1'b0;
               state_d = BUS;
            end
         end
         BUS: begin
            // A flushed cycle still runs to ack/expiry; it just reports nothing.
            if (wb_ack_i) begin
               cyc_d = 1'b0;
               if (kill) begin
                  state_d = IDLE;
               end else begin
                  resp_d  = 1'b1;
                  state_d = RESP;
                  if (!we_q) rdata_d = wb_dat_i;
               end
            end else if (wdog_q == WD_LAST) begin
               cyc_d = 1'b0;
               if (kill) begin
                  state_d = IDLE;
               end else begin
                  rdata_d   = '0;
                  resp_d    = 1'b1;
                  timeout_d = 1'b1;
                  state_d   = RESP;
               end
            end else begin
               if (wdog_q != WD_SAT) wdog_d = wdog_q + 1'b1;
               if (!request) abort_d = 1'b1;
            end
         end
         RESP: begin
            wdog_d  = '0;
            abort_d = 1'b0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= IDLE;
         cyc_q     <= 1'b0;
         we_q      <= 1'b0;
         sel_q     <= '0;
         adr_q     <= '0;
         dat_q     <= '0;
         rdata_q   <= '0;
         resp_q    <= 1'b0;
         timeout_q <= 1'b0;
         wdog_q    <= '0;
         abort_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cyc_q     <= cyc_d;
         we_q      <= we_d;
         sel_q     <= sel_d;
         adr_q     <= adr_d;
         dat_q     <= dat_d;
         rdata_q   <= rdata_d;
         resp_q    <= resp_d;
         timeout_q <= timeout_d;
         wdog_q    <= wdog_d;
         abort_q   <= abort_d;
      end
   end

   assign dmem_resp   = resp_q;
   assign dmem_rdata  = rdata_q;
   assign bus_timeout = timeout_q;
   assign wb_cyc_o    = cyc_q;
   assign wb_stb_o    = cyc_q;
   assign wb_we_o     = we_q;
   assign wb_sel_o    = sel_q;
   assign wb_adr_o    = adr_q;
   assign wb_dat_o    = dat_q;
endmodule

// File: tb/tb_dmem_bus_bridge.sv
// tb/tb_dmem_bus_bridge.sv - self-checking bench for dmem_bus_bridge with a cycle-level reference model
// Directed accesses with scripted ack delays; model compared every cycle plus literal expectations.
module tb_dmem_bus_bridge;
   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        dmem_action_cyc = 1'b0;
   logic        dmem_action_stb = 1'b0;
   logic        dmem_write = 1'b0;
   logic [1:0]  dmem_byte_enable = 2'b00;
   logic [15:0] dmem_address = 16'h0;
   logic [15:0] dmem_wdata = 16'h0;
   logic        dmem_resp;
   logic [15:0] dmem_rdata;
   logic        bus_timeout;
   logic        wb_cyc_o, wb_stb_o, wb_we_o;
   logic [1:0]  wb_sel_o;
   logic [15:0] wb_adr_o, wb_dat_o;
   logic [15:0] wb_dat_i = 16'hDEAD;
   logic        wb_ack_i = 1'b0;

   int checks = 0;
   int errors = 0;
   bit cmp_en = 1'b0;

   dmem_bus_bridge #(.TIMEOUT_CYCLES(TMO), .DATA_WIDTH(16), .ADDR_WIDTH(16)) dut (
      .clk(clk), .reset_n(reset_n),
      .dmem_action_cyc(dmem_action_cyc), .dmem_action_stb(dmem_action_stb),
      .dmem_write(dmem_write), .dmem_byte_enable(dmem_byte_enable),
      .dmem_address(dmem_address), .dmem_wdata(dmem_wdata),
      .dmem_resp(dmem_resp), .dmem_rdata(dmem_rdata), .bus_timeout(bus_timeout),
      .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
      .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one "bus in flight" record, counting bus cycles elapsed.
   logic        m_busy, m_resp, m_to, m_we, m_dead;
   logic [1:0]  m_sel;
   logic [15:0] m_adr, m_dat, m_rdata;
   int          m_cnt;
   wire         req_in = dmem_action_cyc & dmem_action_stb;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_busy <= 0; m_resp <= 0; m_to <= 0; m_we <= 0; m_dead <= 0;
         m_sel <= 0; m_adr <= 0; m_dat <= 0; m_rdata <= 0; m_cnt <= 0;
      end else if (m_resp) begin
         m_resp <= 0;
         m_to   <= 0;
      end else if (!m_busy) begin
         if (req_in) begin
            m_busy <= 1; m_we <= dmem_write; m_sel <= dmem_byte_enable;
            m_adr <= dmem_address & 16'hFFFE; m_dat <= dmem_wdata;
            m_cnt <= 1; m_dead <= 0;
         end
      end else if (wb_ack_i || m_cnt == TMO) begin
         m_busy <= 0;
         if (!m_dead && req_in) begin
            m_resp <= 1;
            m_to   <= !wb_ack_i;
            if (!wb_ack_i) m_rdata <= 16'h0000;
            else if (!m_we) m_rdata <= wb_dat_i;
         end
      end else begin
         m_cnt <= m_cnt + 1;
         if (!req_in) m_dead <= 1;
      end
   end

   initial forever begin
      @(negedge clk);
      if (cmp_en) begin
         chk("dmem_resp", 32'(dmem_resp), 32'(m_resp));
         chk("dmem_rdata", 32'(dmem_rdata), 32'(m_rdata));
         chk("bus_timeout", 32'(bus_timeout), 32'(m_to));
         chk("wb_cyc_o", 32'(wb_cyc_o), 32'(m_busy));
         chk("wb_stb_o", 32'(wb_stb_o), 32'(m_busy));
         chk("wb_we_o", 32'(wb_we_o), 32'(m_we));
         chk("wb_sel_o", 32'(wb_sel_o), 32'(m_sel));
         chk("wb_adr_o", 32'(wb_adr_o), 32'(m_adr));
         chk("wb_dat_o", 32'(wb_dat_o), 32'(m_dat));
      end
   end

   // Slave: ack on the ack_k-th cycle of strobe (0 = first), never if negative.
   int          ack_k = -1;
   logic [15:0] ack_data = 16'h0;
   initial begin : slave
      int bcnt;
      bcnt = 0;
      forever begin
         @(negedge clk);
         if (wb_stb_o) begin
            wb_ack_i = (bcnt == ack_k);
            wb_dat_i = (bcnt == ack_k) ? ack_data : 16'hDEAD;
            bcnt++;
         end else begin
            bcnt = 0;
            wb_ack_i = 1'b0;
            wb_dat_i = 16'hDEAD;
         end
      end
   end

   // Transaction monitor feeding the literal expectations.
   int ncnt = 0, rise_n = 0, rise_cnt = 0, resp_n = 0, resp_cnt = 0, to_cnt = 0, hi_cnt = 0;
   logic        stb_prev = 1'b0, cap_we = 1'b0;
   logic [1:0]  cap_sel = 2'b0;
   logic [15:0] cap_adr = 16'h0, cap_dat = 16'h0, resp_rdata = 16'h0;
   initial forever begin
      @(negedge clk);
      ncnt++;
      if (wb_stb_o && !stb_prev) begin
         rise_n = ncnt; rise_cnt++; hi_cnt = 1;
         cap_adr = wb_adr_o; cap_sel = wb_sel_o; cap_we = wb_we_o; cap_dat = wb_dat_o;
      end else if (wb_stb_o) hi_cnt++;
      if (dmem_resp) begin resp_n = ncnt; resp_cnt++; resp_rdata = dmem_rdata; end
      if (bus_timeout && dmem_resp) to_cnt++;
      stb_prev = wb_stb_o;
   end

   task automatic issue(input logic we, input logic [1:0] be, input logic [15:0] a, input logic [15:0] wd);
      dmem_write = we; dmem_byte_enable = be; dmem_address = a; dmem_wdata = wd;
      dmem_action_cyc = 1'b1; dmem_action_stb = 1'b1;
   endtask

   task automatic drop();
      dmem_action_cyc = 1'b0; dmem_action_stb = 1'b0;
   endtask

   task automatic wait_resp(input string name, input int maxc);
      int  start;
      bit  ok;
      start = resp_cnt;
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #2;
         if (resp_cnt > start) begin ok = 1; break; end
      end
      chk(name, 32'(ok), 1);
   endtask

   task automatic wait_rise(input string name, input int maxc);
      int  start;
      bit  ok;
      start = rise_cnt;
      ok = 0;
      for (int i = 0; i < maxc; i++) begin
         @(negedge clk); #2;
         if (rise_cnt > start) begin ok = 1; break; end
      end
      chk(name, 32'(ok), 1);
   endtask

   task automatic idle_cycles(input int n);
      for (int i = 0; i < n; i++) begin @(negedge clk); #2; end
   endtask

   initial begin
      int base;
      repeat (3) @(posedge clk);
      cmp_en = 1'b1;
      @(negedge clk); #2;
      chk("reset_cyc", 32'(wb_cyc_o), 0);
      chk("reset_rdata", 32'(dmem_rdata), 0);
      chk("reset_resp", 32'(dmem_resp), 0);
      reset_n = 1'b1;
      idle_cycles(2);

      // 1: minimum-latency load
      ack_k = 0; ack_data = 16'hBEEF;
      issue(1'b0, 2'b11, 16'h1234, 16'h0);
      wait_resp("t1_resp", 20);
      drop();
      chk("t1_adr", 32'(cap_adr), 32'h1234);
      chk("t1_sel", 32'(cap_sel), 32'h3);
      chk("t1_we", 32'(cap_we), 0);
      chk("t1_latency", 32'(resp_n - rise_n), 1);
      chk("t1_rdata", 32'(resp_rdata), 32'hBEEF);
      idle_cycles(3);

      // 2: high-byte store, ack on sixth strobe cycle
      ack_k = 5; ack_data = 16'h9999;
      issue(1'b1, 2'b10, 16'h0101, 16'hAB00);
      wait_resp("t2_resp", 30);
      drop();
      chk("t2_adr", 32'(cap_adr), 32'h0100);
      chk("t2_sel", 32'(cap_sel), 32'h2);
      chk("t2_we", 32'(cap_we), 1);
      chk("t2_dat", 32'(cap_dat), 32'hAB00);
      chk("t2_latency", 32'(resp_n - rise_n), 6);
      chk("t2_rdata_kept", 32'(resp_rdata), 32'hBEEF);
      idle_cycles(3);

      // 3: flush two cycles in (strobe only), bus completes silently
      ack_k = 4; ack_data = 16'h5555;
      base = resp_cnt;
      issue(1'b0, 2'b11, 16'h2000, 16'h0);
      wait_rise("t3_rise", 10);
      idle_cycles(2);
      dmem_action_stb = 1'b0;
      idle_cycles(12);
      chk("t3_no_resp", 32'(resp_cnt - base), 0);
      chk("t3_cyc_held", 32'(hi_cnt), 5);
      chk("t3_rdata", 32'(dmem_rdata), 32'hBEEF);
      drop();
      ack_k = 1; ack_data = 16'h1111;
      issue(1'b0, 2'b01, 16'h2222, 16'h0);
      wait_resp("t3b_resp", 20);
      drop();
      chk("t3b_rdata", 32'(resp_rdata), 32'h1111);
      chk("t3b_latency", 32'(resp_n - rise_n), 2);
      idle_cycles(3);

      // 4: watchdog expiry, then ack on the last permitted cycle
      ack_k = -1;
      issue(1'b0, 2'b11, 16'h3332, 16'h0);
      wait_resp("t4_resp", 30);
      drop();
      chk("t4_timeout", 32'(to_cnt), 1);
      chk("t4_bus_cycles", 32'(hi_cnt), 8);
      chk("t4_rdata", 32'(resp_rdata), 0);
      chk("t4_latency", 32'(resp_n - rise_n), 8);
      idle_cycles(3);
      ack_k = 7; ack_data = 16'h7E57;
      issue(1'b0, 2'b11, 16'h3334, 16'h0);
      wait_resp("t4b_resp", 30);
      drop();
      chk("t4b_no_timeout", 32'(to_cnt), 1);
      chk("t4b_rdata", 32'(resp_rdata), 32'h7E57);
      idle_cycles(3);

      // 5: LDI-style held request re-issues with the new address
      ack_k = 0; ack_data = 16'h4000;
      base = resp_cnt;
      issue(1'b0, 2'b11, 16'h3000, 16'h0);
      wait_resp("t5_first", 20);
      chk("t5_first_rdata", 32'(dmem_rdata), 32'h4000);
      dmem_address = 16'h4000;
      ack_data = 16'h7777;
      wait_resp("t5_second", 20);
      drop();
      chk("t5_adr", 32'(cap_adr), 32'h4000);
      chk("t5_rdata", 32'(resp_rdata), 32'h7777);
      idle_cycles(4);
      chk("t5_resp_count", 32'(resp_cnt - base), 2);

      // 6: asynchronous reset mid-cycle
      ack_k = -1;
      base = resp_cnt;
      issue(1'b0, 2'b11, 16'h5000, 16'h0);
      wait_rise("t6_rise", 10);
      idle_cycles(2);
      reset_n = 1'b0;
      #1;
      chk("t6_cyc", 32'(wb_cyc_o), 0);
      chk("t6_stb", 32'(wb_stb_o), 0);
      chk("t6_adr", 32'(wb_adr_o), 0);
      chk("t6_rdata", 32'(dmem_rdata), 0);
      drop();
      idle_cycles(3);
      reset_n = 1'b1;
      idle_cycles(10);
      chk("t6_no_resp", 32'(resp_cnt - base), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "bench time limit");
   end
endmodule
